// File: rtl/dmem_ahb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ahb_ctrl
// Desc     : Round-robin load/store sequencer driving an AHB-Lite data master.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ahb_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        st_req_in,
  input  logic [31:0] st_addr_in,
  input  logic [31:0] st_data_in,
  input  logic [3:0]  st_mask_in,
  input  logic [1:0]  st_size_in,
  input  logic        ld_req_in,
  input  logic [31:0] ld_addr_in,
  input  logic [1:0]  ld_size_in,
  output logic        st_ack_out,
  output logic        ld_ack_out,
  output logic [31:0] ld_data_out,
  output logic        bus_err_out,
  output logic        stall_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  output logic [3:0]  wr_mask_out,
  input  logic        hready_in,
  input  logic        hresp_in,
  input  logic [31:0] hrdata_in
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_ADDR = 2'd1;
  localparam logic [1:0] C_DATA = 2'd2;
  localparam logic [1:0] C_ERR  = 2'd3;
  localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        last_st_q, last_st_d;   // 1: the store won the most recent grant
  logic        is_st_q, is_st_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  wait_q, wait_d;
  logic        st_ack_q, st_ack_d;
  logic        ld_ack_q, ld_ack_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic w_grant_st;
  logic w_timeout;
  logic w_done;
  logic w_fail;

  assign w_grant_st = st_req_in & (~ld_req_in | ~last_st_q);
  assign w_timeout  = (wait_q == C_WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    last_st_d = last_st_q;
    is_st_d   = is_st_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    size_d    = size_q;
    wait_d    = wait_q;
    st_ack_d  = 1'b0;
    ld_ack_d  = 1'b0;
    err_d     = 1'b0;
    ld_data_d = ld_data_q;
    w_done    = 1'b0;
    w_fail    = 1'b0;

    case (state_q)
      C_IDLE: begin
        // An ack cycle is skipped: the requester is retiring that request.
        if (!(st_ack_q | ld_ack_q) && (st_req_in | ld_req_in)) begin
          last_st_d = w_grant_st;
          is_st_d   = w_grant_st;
          addr_d    = w_grant_st ? st_addr_in : ld_addr_in;
          size_d    = w_grant_st ? st_size_in : ld_size_in;
          data_d    = st_data_in;
          mask_d    = st_mask_in;
          wait_d    = 8'd0;
          state_d   = C_ADDR;
        end
      end
      C_ADDR: begin
        if (hready_in) begin
          state_d = C_DATA;
          wait_d  = 8'd0;
        end else if (w_timeout) begin
          w_done = 1'b1;
          w_fail = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      C_DATA: begin
        if (hready_in) begin
          w_done = 1'b1;
          w_fail = hresp_in;
        end else if (hresp_in) begin
          state_d = C_ERR;
          wait_d  = 8'd0;
        end else if (w_timeout) begin
          w_done = 1'b1;
          w_fail = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        if (hready_in || w_timeout) begin
          w_done = 1'b1;
          w_fail = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
    endcase

    if (w_done) begin
      state_d  = C_IDLE;
      wait_d   = 8'd0;
      st_ack_d = is_st_q;
      ld_ack_d = ~is_st_q;
      err_d    = w_fail;
      if (!w_fail && !is_st_q) begin
        ld_data_d = hrdata_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= C_IDLE;
      last_st_q <= 1'b0;
      is_st_q   <= 1'b0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      mask_q    <= 4'd0;
      size_q    <= 2'd0;
      wait_q    <= 8'd0;
      st_ack_q  <= 1'b0;
      ld_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      ld_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      last_st_q <= last_st_d;
      is_st_q   <= is_st_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      size_q    <= size_d;
      wait_q    <= wait_d;
      st_ack_q  <= st_ack_d;
      ld_ack_q  <= ld_ack_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign st_ack_out  = st_ack_q;
  assign ld_ack_out  = ld_ack_q;
  assign bus_err_out = err_q;
  assign ld_data_out = ld_data_q;
  assign stall_out   = (st_req_in | ld_req_in) & ~(st_ack_q | ld_ack_q);

  // Address-phase signals are only driven in ADDR, write data only in a store's DATA.
  assign htrans_out  = (state_q == C_ADDR) ? 2'b10 : 2'b00;
  assign haddr_out   = (state_q == C_ADDR) ? addr_q : 32'd0;
  assign hwrite_out  = (state_q == C_ADDR) & is_st_q;
  assign hsize_out   = (state_q != C_ADDR) ? 3'b000 :
                       (size_q[1] ? 3'b010 : {1'b0, size_q});
  assign hwdata_out  = ((state_q == C_DATA) && is_st_q) ? data_q : 32'd0;
  assign wr_mask_out = ((state_q == C_DATA) && is_st_q) ? mask_q : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ahb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ahb_ctrl
// Desc     : Directed plus randomized bench for dmem_ahb_ctrl against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ahb_ctrl;

  localparam int TMO = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        st_req_in, ld_req_in;
  logic [31:0] st_addr_in, st_data_in, ld_addr_in;
  logic [3:0]  st_mask_in;
  logic [1:0]  st_size_in, ld_size_in;
  logic        st_ack_out, ld_ack_out, bus_err_out, stall_out, hwrite_out;
  logic [31:0] ld_data_out, haddr_out, hwdata_out;
  logic [1:0]  htrans_out;
  logic [2:0]  hsize_out;
  logic [3:0]  wr_mask_out;
  logic        hready_in, hresp_in;
  logic [31:0] hrdata_in;

  int total = 0;
  int bad   = 0;

  dmem_ahb_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .st_req_in(st_req_in), .st_addr_in(st_addr_in), .st_data_in(st_data_in),
    .st_mask_in(st_mask_in), .st_size_in(st_size_in),
    .ld_req_in(ld_req_in), .ld_addr_in(ld_addr_in), .ld_size_in(ld_size_in),
    .st_ack_out(st_ack_out), .ld_ack_out(ld_ack_out), .ld_data_out(ld_data_out),
    .bus_err_out(bus_err_out), .stall_out(stall_out),
    .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
    .hsize_out(hsize_out), .hwdata_out(hwdata_out), .wr_mask_out(wr_mask_out),
    .hready_in(hready_in), .hresp_in(hresp_in), .hrdata_in(hrdata_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one in-flight transfer described by its phase and
  // the number of consecutive not-ready cycles spent in that phase.
  typedef enum int {P_NONE, P_ADR, P_DAT, P_ERR} ph_t;
  ph_t         m_ph = P_NONE;
  logic        m_st = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0, m_ld_data = '0;
  logic [3:0]  m_mask = '0;
  logic [1:0]  m_size = '0;
  int          m_stuck = 0;
  logic        m_last_st = 1'b0;
  logic        m_st_ack = 1'b0, m_ld_ack = 1'b0, m_err = 1'b0;
  bit          m_armed = 1'b0;

  task automatic model_step();
    bit fin, failed, prev_ack;
    fin = 1'b0;
    failed = 1'b0;
    if (rst_in) begin
      m_ph = P_NONE; m_last_st = 1'b0; m_stuck = 0;
      m_st_ack = 1'b0; m_ld_ack = 1'b0; m_err = 1'b0; m_ld_data = '0;
      m_armed = 1'b1;
      return;
    end
    prev_ack = m_st_ack | m_ld_ack;
    m_st_ack = 1'b0; m_ld_ack = 1'b0; m_err = 1'b0;
    case (m_ph)
      P_NONE: if (!prev_ack && (st_req_in || ld_req_in)) begin
        m_st      = st_req_in && !(ld_req_in && m_last_st);
        m_last_st = m_st;
        m_addr    = m_st ? st_addr_in : ld_addr_in;
        m_size    = m_st ? st_size_in : ld_size_in;
        m_data    = st_data_in;
        m_mask    = st_mask_in;
        m_ph      = P_ADR;
        m_stuck   = 0;
      end
      P_ADR: if (hready_in) begin
        m_ph = P_DAT; m_stuck = 0;
      end else begin
        m_stuck++;
        if (m_stuck >= TMO) begin fin = 1'b1; failed = 1'b1; end
      end
      P_DAT: if (hready_in) begin
        fin = 1'b1; failed = hresp_in;
        if (!hresp_in && !m_st) m_ld_data = hrdata_in;
      end else if (hresp_in) begin
        m_ph = P_ERR; m_stuck = 0;
      end else begin
        m_stuck++;
        if (m_stuck >= TMO) begin fin = 1'b1; failed = 1'b1; end
      end
      P_ERR: begin
        m_stuck++;
        if (hready_in || m_stuck >= TMO) begin fin = 1'b1; failed = 1'b1; end
      end
    endcase
    if (fin) begin
      m_ph = P_NONE;
      m_st_ack = m_st; m_ld_ack = !m_st; m_err = failed;
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  always @(negedge clk_in) begin
    if (m_armed) begin
      chk("htrans",  32'(htrans_out),  (m_ph == P_ADR) ? 32'd2 : 32'd0);
      chk("haddr",   haddr_out,        (m_ph == P_ADR) ? m_addr : 32'd0);
      chk("hwrite",  32'(hwrite_out),  32'((m_ph == P_ADR) && m_st));
      chk("hsize",   32'(hsize_out),   (m_ph != P_ADR) ? 32'd0 : (m_size[1] ? 32'd2 : 32'(m_size)));
      chk("hwdata",  hwdata_out,       (m_ph == P_DAT && m_st) ? m_data : 32'd0);
      chk("wr_mask", 32'(wr_mask_out), (m_ph == P_DAT && m_st) ? 32'(m_mask) : 32'd0);
      chk("st_ack",  32'(st_ack_out),  32'(m_st_ack));
      chk("ld_ack",  32'(ld_ack_out),  32'(m_ld_ack));
      chk("bus_err", 32'(bus_err_out), 32'(m_err));
      chk("ld_data", ld_data_out,      m_ld_data);
      chk("stall",   32'(stall_out),   32'((st_req_in | ld_req_in) & ~(m_st_ack | m_ld_ack)));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_in);
  endtask

  task automatic new_store();
    st_addr_in = $urandom & 32'hFFFF_FFFC;
    st_data_in = $urandom;
    st_mask_in = 4'($urandom);
    st_size_in = 2'($urandom);
  endtask

  task automatic new_load();
    ld_addr_in = $urandom;
    ld_size_in = 2'($urandom);
  endtask

  bit slow;

  initial begin
    rst_in = 1'b1; st_req_in = 1'b0; ld_req_in = 1'b0;
    st_addr_in = '0; st_data_in = '0; st_mask_in = '0; st_size_in = '0;
    ld_addr_in = '0; ld_size_in = '0;
    hready_in = 1'b1; hresp_in = 1'b0; hrdata_in = '0;
    slow = 1'b0;

    tick(); tick(); rst_in = 1'b0; mid();
    chk("rst_htrans", 32'(htrans_out), 32'd0);
    chk("rst_acks", 32'({st_ack_out, ld_ack_out, bus_err_out}), 32'd0);
    chk("rst_ld_data", ld_data_out, 32'd0);

    // Zero-wait word store
    tick(); st_req_in = 1'b1; st_addr_in = 32'h100; st_data_in = 32'hDEADBEEF;
    st_mask_in = 4'hF; st_size_in = 2'b10; mid();
    chk("ws_stall", 32'(stall_out), 32'd1);
    tick(); mid();
    chk("ws_htrans", 32'(htrans_out), 32'd2);
    chk("ws_haddr", haddr_out, 32'h100);
    chk("ws_hwrite", 32'(hwrite_out), 32'd1);
    chk("ws_hsize", 32'(hsize_out), 32'd2);
    tick(); mid();
    chk("ws_hwdata", hwdata_out, 32'hDEADBEEF);
    chk("ws_mask", 32'(wr_mask_out), 32'hF);
    tick(); st_req_in = 1'b0; mid();
    chk("ws_ack", 32'({st_ack_out, bus_err_out}), 32'b10);

    // Byte load with two data-phase wait states
    tick(); ld_req_in = 1'b1; ld_addr_in = 32'h103; ld_size_in = 2'b00; mid();
    tick(); mid();
    chk("bl_hsize", 32'(hsize_out), 32'd0);
    chk("bl_haddr", haddr_out, 32'h103);
    tick(); hready_in = 1'b0; mid();
    tick(); mid();
    chk("bl_no_ack", 32'(ld_ack_out), 32'd0);
    tick(); hready_in = 1'b1; hrdata_in = 32'h11223344; mid();
    tick(); ld_req_in = 1'b0; mid();
    chk("bl_ack", 32'(ld_ack_out), 32'd1);
    chk("bl_data", ld_data_out, 32'h11223344);

    // Simultaneous requests: store first, one idle cycle, then the load
    tick(); hrdata_in = 32'h55AA55AA;
    st_req_in = 1'b1; st_addr_in = 32'h200; st_data_in = 32'h12345678;
    st_mask_in = 4'b0011; st_size_in = 2'b01;
    ld_req_in = 1'b1; ld_addr_in = 32'h300; ld_size_in = 2'b10; mid();
    tick(); mid();
    chk("rr_first_st", 32'(hwrite_out), 32'd1);
    chk("rr_first_addr", haddr_out, 32'h200);
    tick(); tick(); st_req_in = 1'b0; mid();
    chk("rr_st_ack", 32'({st_ack_out, ld_ack_out}), 32'b10);
    tick(); mid();
    chk("rr_gap", 32'(htrans_out), 32'd0);
    tick(); mid();
    chk("rr_ld_addr", haddr_out, 32'h300);
    tick(); tick(); ld_req_in = 1'b0; mid();
    chk("rr_ld_ack", 32'(ld_ack_out), 32'd1);
    chk("rr_ld_data", ld_data_out, 32'h55AA55AA);

    // Store that receives a two-cycle ERROR response
    tick(); st_req_in = 1'b1; st_addr_in = 32'h400; st_data_in = 32'hA5A5A5A5;
    st_mask_in = 4'b1000; st_size_in = 2'b00;
    tick();
    tick(); hready_in = 1'b0; hresp_in = 1'b1;
    tick(); hready_in = 1'b1; mid();
    chk("er_pending", 32'(st_ack_out), 32'd0);
    tick(); st_req_in = 1'b0; hresp_in = 1'b0; mid();
    chk("er_ack", 32'({st_ack_out, bus_err_out}), 32'b11);
    chk("er_ld_data", ld_data_out, 32'h55AA55AA);

    // Address phase never accepted: timeout after TMO stalled cycles
    tick(); ld_req_in = 1'b1; ld_addr_in = 32'h500; ld_size_in = 2'b10; hready_in = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      tick(); mid();
      chk("to_addr_held", 32'(htrans_out), 32'd2);
    end
    tick(); ld_req_in = 1'b0; hready_in = 1'b1; mid();
    chk("to_ack", 32'({ld_ack_out, bus_err_out}), 32'b11);
    chk("to_htrans", 32'(htrans_out), 32'd0);
    chk("to_ld_data", ld_data_out, 32'h55AA55AA);

    // Reset during a load's data phase, then the held request is served
    tick(); ld_req_in = 1'b1; ld_addr_in = 32'h600; ld_size_in = 2'b01; hrdata_in = 32'h0BADF00D;
    tick();
    tick(); hready_in = 1'b0; rst_in = 1'b1;
    tick(); rst_in = 1'b0; hready_in = 1'b1; mid();
    chk("rd_acks", 32'({ld_ack_out, st_ack_out, bus_err_out}), 32'd0);
    chk("rd_ld_data", ld_data_out, 32'd0);
    tick(); mid();
    chk("rd_regrant", haddr_out, 32'h600);
    tick(); tick(); ld_req_in = 1'b0; mid();
    chk("rd_ack", 32'(ld_ack_out), 32'd1);
    chk("rd_data", ld_data_out, 32'h0BADF00D);

    // Randomized traffic with occasional slow slaves, errors and resets
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_in = (($urandom % 400) == 0);
      if ((c % 64) == 0) slow = (($urandom % 3) == 0);
      hready_in = slow ? (($urandom % 5) == 0) : (($urandom % 10) < 8);
      hresp_in  = (($urandom % 8) == 0);
      hrdata_in = $urandom;
      if (st_req_in && st_ack_out) begin
        st_req_in = (($urandom % 3) == 0);
        if (st_req_in) new_store();
      end else if (!st_req_in && (($urandom % 3) == 0)) begin
        st_req_in = 1'b1; new_store();
      end
      if (ld_req_in && ld_ack_out) begin
        ld_req_in = (($urandom % 3) == 0);
        if (ld_req_in) new_load();
      end else if (!ld_req_in && (($urandom % 3) == 0)) begin
        ld_req_in = 1'b1; new_load();
      end
    end

    tick(); mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
